instr_encode: RTL and testbench

INSTR_ENCODE -- requirements
Module: instr_encode

---
 rtl/instr_enc_pkg.sv | 52 +++++
 rtl/instr_pack.sv | 51 +++++
 rtl/instr_encode.sv | 139 +++++++++++++
 tb/tb_instr_encode.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: format and FSM encodings,
// instruction field bit positions, and the I-format immediate range check.
package instr_enc_pkg;

    // Instruction format selector as presented on fmt_i
    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_ILL = 2'd3
    } fmt_t;

    // Job-level state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Field bit positions, shared with the instruction decoder
    localparam int OP_HI     = 31;
    localparam int OP_LO     = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;

    // True when a 32-bit immediate fits the 16-bit I-format field.
    // Signed: bits [31:15] must all be copies of the sign bit.
    // Unsigned: bits [31:16] must be zero.
    function automatic logic imm_in_range(input logic [31:0] imm,
                                          input logic        sign_ext);
        logic ok;
        if (sign_ext) begin
            ok = (imm[31:15] == 17'h00000) || (imm[31:15] == 17'h1FFFF);
        end else begin
            ok = (imm[31:16] == 16'h0000);
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: assembles the 32-bit instruction word from its
// fields and flags words that cannot be encoded (bad format or an
// immediate that does not fit).
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic        sign_ext,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Pack fields according to format and apply the immediate range check
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (fmt_t'(fmt))
            FMT_R: begin
                word[OP_HI:OP_LO]       = op;
                word[RS_HI:RS_LO]       = rs;
                word[RT_HI:RT_LO]       = rt;
                word[RD_HI:RD_LO]       = rd;
                word[SHAMT_HI:SHAMT_LO] = shamt;
                word[FUNCT_HI:FUNCT_LO] = funct;
            end
            FMT_I: begin
                word[OP_HI:OP_LO]   = op;
                word[RS_HI:RS_LO]   = rs;
                word[RT_HI:RT_LO]   = rt;
                word[IMM_HI:IMM_LO] = imm[15:0];
                illegal             = !imm_in_range(imm, sign_ext);
            end
            FMT_J: begin
                word[OP_HI:OP_LO]         = op;
                word[TARGET_HI:TARGET_LO] = target;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode.sv
// Instruction encoder: runs a load job of len_i words starting at base_i,
// packs each accepted field set into an instruction word and presents it
// with its byte address through a one-deep output register. Words that
// cannot be encoded are consumed, counted and reported instead of emitted.
//
// Handshakes: on both sides a transfer happens on a rising clk edge where
// valid and ready are both 1. valid_o, once raised, stays up with instr_o and
// addr_o held stable until ready_i retires it. ready_o is combinational:
// RUN, fewer than len words accepted, and the output register is either
// empty or being retired this cycle, so accept and retire overlap at full rate.
module instr_encode
    import instr_enc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] base_i,
    input  logic [15:0] len_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  fmt_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [31:0] imm_i,
    input  logic        sign_ext_i,
    input  logic [25:0] target_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o,
    output logic        done_o,
    output logic [1:0]  dbg_state
);

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] acc_cnt;
    logic [31:0] addr_cnt;

    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        accept;
    logic        accept_legal;
    logic        accept_illegal;
    logic        retire;

    instr_pack u_pack (
        .fmt      (fmt_i),
        .op       (op_i),
        .funct    (funct_i),
        .rs       (rs_i),
        .rt       (rt_i),
        .rd       (rd_i),
        .shamt    (shamt_i),
        .imm      (imm_i),
        .sign_ext (sign_ext_i),
        .target   (target_i),
        .word     (packed_word),
        .illegal  (packed_illegal)
    );

    assign ready_o        = (state == ST_RUN) && (acc_cnt < len_q) && (!valid_o || ready_i);
    assign accept         = valid_i && ready_o;
    assign accept_legal   = accept && !packed_illegal;
    assign accept_illegal = accept && packed_illegal;
    assign retire         = valid_o && ready_i;
    assign done_o         = (state == ST_DONE);
    assign dbg_state      = state;

    // Job FSM plus the job counters (length, accepted count, address, errors)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= 16'h0000;
            acc_cnt   <= 16'h0000;
            addr_cnt  <= 32'h0000_0000;
            err_cnt_o <= 16'h0000;
            err_o     <= 1'b0;
        end else begin
            err_o <= accept_illegal;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q     <= len_i;
                        acc_cnt   <= 16'h0000;
                        addr_cnt  <= base_i;
                        err_cnt_o <= 16'h0000;
                        state     <= (len_i != 16'h0000) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 16'd1;
                    end
                    if (accept_legal) begin
                        addr_cnt <= addr_cnt + 32'd4;
                    end
                    if (accept_illegal && (err_cnt_o != 16'hFFFF)) begin
                        err_cnt_o <= err_cnt_o + 16'd1;
                    end
                    // Finish only once every word is consumed and the last one has left
                    if ((acc_cnt == len_q) && !valid_o) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // One-deep output register: load on legal accept, clear on retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o <= 1'b0;
            instr_o <= 32'h0000_0000;
            addr_o  <= 32'h0000_0000;
        end else begin
            if (accept_legal) begin
                valid_o <= 1'b1;
                instr_o <= packed_word;
                addr_o  <= addr_cnt;
            end else if (retire) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: each task drives one scenario and checks
// outputs against hand-computed encodings and addresses.
module tb_instr_encode;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [31:0] base_i;
    logic [15:0] len_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  fmt_i;
    logic [5:0]  op_i;
    logic [5:0]  funct_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [4:0]  shamt_i;
    logic [31:0] imm_i;
    logic        sign_ext_i;
    logic [25:0] target_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic        done_o;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    instr_encode dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .base_i     (base_i),
        .len_i      (len_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .fmt_i      (fmt_i),
        .op_i       (op_i),
        .funct_i    (funct_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .shamt_i    (shamt_i),
        .imm_i      (imm_i),
        .sign_ext_i (sign_ext_i),
        .target_i   (target_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .instr_o    (instr_o),
        .addr_o     (addr_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o),
        .done_o     (done_o),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [31:0] base, input logic [15:0] len);
        start_i = 1'b1;
        base_i  = base;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic drive_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        fmt_i = 2'd0; op_i = op; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh; funct_i = fn;
        valid_i = 1'b1;
    endtask

    task automatic drive_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] imm, input logic se);
        fmt_i = 2'd1; op_i = op; rs_i = rs; rt_i = rt; imm_i = imm; sign_ext_i = se;
        valid_i = 1'b1;
    endtask

    task automatic drive_j(input logic [5:0] op, input logic [25:0] tgt);
        fmt_i = 2'd2; op_i = op; target_i = tgt;
        valid_i = 1'b1;
    endtask

    // Waits (bounded) for done_o; reports whether it was seen
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({valid_o, ready_o, err_o, done_o} !== 4'b0000 || instr_o !== 32'h0 ||
            addr_o !== 32'h0 || err_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b r=%b e=%b d=%b i=%h a=%h c=%h want all 0",
                     valid_o, ready_o, err_o, done_o, instr_o, addr_o, err_cnt_o);
        end
        reset = 1'b0;
        valid_i = 1'b1;
        fmt_i = 2'd0;
        tick(); tick();
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_activity: got r=%b v=%b d=%b want 0 0 0", ready_o, valid_o, done_o);
        end
        valid_i = 1'b0;
    endtask

    task automatic test_r_format();
        bit seen;
        ready_i = 1'b1;
        drive_start(32'h0040_0000, 16'd1);
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL r_ready: got %b want 1", ready_o);
        end
        drive_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || instr_o !== 32'h0022_1820 || addr_o !== 32'h0040_0000) begin
            failures++;
            $display("FAIL r_word: got v=%b i=%h a=%h want 1 00221820 00400000", valid_o, instr_o, addr_o);
        end
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL r_early_done: got %b want 0", done_o);
        end
        tick();
        wait_done(seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL r_done: got no done_o pulse want pulse after retire");
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL r_done_width: got %b want 0", done_o);
        end
    endtask

    task automatic test_i_format();
        bit seen;
        ready_i = 1'b1;
        drive_start(32'h0000_0100, 16'd2);
        drive_i(6'h08, 5'd0, 5'd8, 32'hFFFF_FFFF, 1'b1);
        tick();
        checks++;
        if (valid_o !== 1'b1 || instr_o !== 32'h2008_FFFF || addr_o !== 32'h0000_0100 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL i_signed: got v=%b i=%h a=%h e=%b want 1 2008ffff 00000100 0",
                     valid_o, instr_o, addr_o, err_o);
        end
        drive_i(6'h08, 5'd0, 5'd8, 32'hFFFF_FFFF, 1'b0);
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || err_o !== 1'b1 || err_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL i_unsigned_drop: got v=%b e=%b c=%0d want 0 1 1", valid_o, err_o, err_cnt_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL i_err_pulse: got e=%b c=%0d want 0 1", err_o, err_cnt_o);
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL i_done: got no done_o pulse want pulse");
        end
        tick();
    endtask

    task automatic test_drop_middle();
        bit seen;
        ready_i = 1'b1;
        drive_start(32'h0000_2000, 16'd3);
        checks++;
        if (err_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL mid_errcnt_clear: got %0d want 0", err_cnt_o);
        end
        drive_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        tick();
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 32'h0000_2000 || instr_o !== 32'h0022_1820) begin
            failures++;
            $display("FAIL mid_first: got v=%b i=%h a=%h want 1 00221820 00002000", valid_o, instr_o, addr_o);
        end
        drive_i(6'h08, 5'd0, 5'd8, 32'h0000_8000, 1'b1);
        tick();
        checks++;
        if (valid_o !== 1'b0 || err_o !== 1'b1 || err_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL mid_drop: got v=%b e=%b c=%0d want 0 1 1", valid_o, err_o, err_cnt_o);
        end
        drive_j(6'd2, 26'h010_0000);
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 32'h0000_2004 || instr_o !== 32'h0810_0000) begin
            failures++;
            $display("FAIL mid_third: got v=%b i=%h a=%h want 1 08100000 00002004", valid_o, instr_o, addr_o);
        end
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_ready_full: got %b want 0", ready_o);
        end
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_early_done: got %b want 0", done_o);
        end
        tick();
        wait_done(seen);
        checks++;
        if (!seen || err_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL mid_done: got seen=%b c=%0d want 1 1", seen, err_cnt_o);
        end
        tick();
    endtask

    task automatic test_j_wrap();
        bit seen;
        ready_i = 1'b1;
        drive_start(32'hFFFF_FFFC, 16'd2);
        drive_j(6'd2, 26'h010_0000);
        tick();
        checks++;
        if (valid_o !== 1'b1 || instr_o !== 32'h0810_0000 || addr_o !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL j_first: got v=%b i=%h a=%h want 1 08100000 fffffffc", valid_o, instr_o, addr_o);
        end
        drive_j(6'd3, 26'h000_0004);
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || instr_o !== 32'h0C00_0004 || addr_o !== 32'h0000_0000) begin
            failures++;
            $display("FAIL j_wrap: got v=%b i=%h a=%h want 1 0c000004 00000000", valid_o, instr_o, addr_o);
        end
        tick();
        wait_done(seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL j_done: got no done_o pulse want pulse");
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0022_2020;
        exp_w[1] = 32'h0022_2820;
        exp_w[2] = 32'h0022_3020;
        exp_w[3] = 32'h0022_3820;
        ready_i = 1'b0;
        drive_start(32'h0000_3000, 16'd4);
        drive_r(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20);
        tick();
        drive_r(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || instr_o !== exp_w[0] || addr_o !== 32'h0000_3000) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b r=%b i=%h a=%h want 1 0 %h 00003000",
                         k, valid_o, ready_o, instr_o, addr_o, exp_w[0]);
            end
            tick();
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 1", ready_o);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || instr_o !== exp_w[k] || addr_o !== 32'h0000_3000 + 32'(4 * k)) begin
                failures++;
                $display("FAIL b2b_word%0d: got v=%b i=%h a=%h want 1 %h %h",
                         k, valid_o, instr_o, addr_o, exp_w[k], 32'h0000_3000 + 32'(4 * k));
            end
            if (k < 3) drive_r(6'd0, 5'd1, 5'd2, 5'(4 + k + 1), 5'd0, 6'h20);
            else valid_i = 1'b0;
        end
        tick();
        wait_done(seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_done: got no done_o pulse want pulse");
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        ready_i = 1'b0;
        drive_start(32'h0000_5000, 16'd2);
        drive_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        tick();
        checks++;
        if (valid_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_valid: got %b want 1", valid_o);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({valid_o, ready_o, err_o, done_o} !== 4'b0000 || instr_o !== 32'h0 ||
            addr_o !== 32'h0 || err_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL rst_async: got v=%b r=%b e=%b d=%b i=%h a=%h c=%h want all 0",
                     valid_o, ready_o, err_o, done_o, instr_o, addr_o, err_cnt_o);
        end
        #2 reset = 1'b0;
        ready_i = 1'b1;
        tick(); tick();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_discard: got v=%b r=%b d=%b want 0 0 0", valid_o, ready_o, done_o);
        end
        valid_i = 1'b0;
        drive_start(32'h0000_6000, 16'd0);
        checks++;
        if (done_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL len0_done: got d=%b v=%b want 1 0", done_o, valid_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL len0_after: got d=%b v=%b want 0 0", done_o, valid_o);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start_i = 1'b0; base_i = '0; len_i = '0; valid_i = 1'b0; ready_i = 1'b0;
        fmt_i = '0; op_i = '0; funct_i = '0; rs_i = '0; rt_i = '0; rd_i = '0;
        shamt_i = '0; imm_i = '0; sign_ext_i = 1'b0; target_i = '0;
        test_reset();
        test_r_format();
        test_i_format();
        test_drop_middle();
        test_j_wrap();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
